// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - MIPS logic/shift decode stage with forwarding, load-use bubble and ID/EX register
module id_stage_pipe #(
    parameter int DATA_W   = 32,
    parameter int RADDR_W  = 5,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_valid_i,
    input  logic [DATA_W-1:0]   pc_i,
    input  logic [31:0]         inst_i,
    output logic                id_ready_o,
    output logic                reg1_read_o,
    output logic                reg2_read_o,
    output logic [RADDR_W-1:0]  reg1_addr_o,
    output logic [RADDR_W-1:0]  reg2_addr_o,
    input  logic [DATA_W-1:0]   reg1_data_i,
    input  logic [DATA_W-1:0]   reg2_data_i,
    input  logic                ex_wreg_i,
    input  logic                ex_load_i,
    input  logic [RADDR_W-1:0]  ex_wd_i,
    input  logic [DATA_W-1:0]   ex_wdata_i,
    input  logic                mem_wreg_i,
    input  logic [RADDR_W-1:0]  mem_wd_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    input  logic                ex_ready_i,
    input  logic                flush_i,
    output logic                ex_valid_o,
    output logic [DATA_W-1:0]   ex_pc_o,
    output logic [ALUOP_W-1:0]  aluOp_o,
    output logic [ALUSEL_W-1:0] aluSel_o,
    output logic [DATA_W-1:0]   reg1_o,
    output logic [DATA_W-1:0]   reg2_o,
    output logic [RADDR_W-1:0]  wd_o,
    output logic                wreg_o,
    output logic                inst_invalid_o,
    output logic [CNT_W-1:0]    stall_cnt_o
);
    localparam logic [5:0] OPC_SPECIAL = 6'h00, OPC_ANDI = 6'h0C, OPC_ORI = 6'h0D;
    localparam logic [5:0] OPC_XORI = 6'h0E, OPC_LUI = 6'h0F;
    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03;
    localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27;
    localparam logic [ALUOP_W-1:0] EXE_NOP_OP = '0;
    localparam logic [ALUOP_W-1:0] EXE_AND_OP = ALUOP_W'(8'h24), EXE_OR_OP  = ALUOP_W'(8'h25);
    localparam logic [ALUOP_W-1:0] EXE_XOR_OP = ALUOP_W'(8'h26), EXE_NOR_OP = ALUOP_W'(8'h27);
    localparam logic [ALUOP_W-1:0] EXE_SLL_OP = ALUOP_W'(8'h7C), EXE_SRL_OP = ALUOP_W'(8'h02);
    localparam logic [ALUOP_W-1:0] EXE_SRA_OP = ALUOP_W'(8'h03);
    localparam logic [ALUSEL_W-1:0] EXE_RES_NOP = '0;
    localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = ALUSEL_W'(3'd1), EXE_RES_SHIFT = ALUSEL_W'(3'd2);
    localparam logic [0:0] ST_RUN = 1'b0, ST_BUBBLE = 1'b1;

    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd, shamt;
    assign opcode = inst_i[31:26];
    assign rs     = inst_i[25:21];
    assign rt     = inst_i[20:16];
    assign rd     = inst_i[15:11];
    assign shamt  = inst_i[10:6];
    assign funct  = inst_i[5:0];

    logic                dec_r1, dec_r2, dec_wreg, dec_inv;
    logic [DATA_W-1:0]   dec_imm;
    logic [ALUOP_W-1:0]  dec_op;
    logic [ALUSEL_W-1:0] dec_sel;
    logic [RADDR_W-1:0]  dec_wd;

    always_comb begin
        dec_r1 = 1'b0; dec_r2 = 1'b0; dec_wreg = 1'b0; dec_inv = 1'b1;
        dec_imm = '0; dec_op = EXE_NOP_OP; dec_sel = EXE_RES_NOP; dec_wd = '0;
        case (opcode)
            OPC_ANDI, OPC_ORI, OPC_XORI, OPC_LUI: begin
                dec_r1 = 1'b1; dec_wreg = 1'b1; dec_inv = 1'b0;
                dec_wd = RADDR_W'(rt); dec_sel = EXE_RES_LOGIC;
                dec_imm = (opcode == OPC_LUI) ? DATA_W'({inst_i[15:0], 16'h0000})
                                              : DATA_W'(inst_i[15:0]);
                case (opcode)
                    OPC_ANDI: dec_op = EXE_AND_OP;
                    OPC_XORI: dec_op = EXE_XOR_OP;
                    default:  dec_op = EXE_OR_OP;
                endcase
            end
            OPC_SPECIAL: begin
                case (funct)
                    FN_AND, FN_OR, FN_XOR, FN_NOR: begin
                        dec_r1 = 1'b1; dec_r2 = 1'b1; dec_wreg = 1'b1; dec_inv = 1'b0;
                        dec_wd = RADDR_W'(rd); dec_sel = EXE_RES_LOGIC;
                        case (funct)
                            FN_AND:  dec_op = EXE_AND_OP;
                            FN_OR:   dec_op = EXE_OR_OP;
                            FN_XOR:  dec_op = EXE_XOR_OP;
                            default: dec_op = EXE_NOR_OP;
                        endcase
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        if (rs == 5'd0) begin
                            dec_r2 = 1'b1; dec_wreg = 1'b1; dec_inv = 1'b0;
                            dec_imm = DATA_W'(shamt); dec_wd = RADDR_W'(rd); dec_sel = EXE_RES_SHIFT;
                            case (funct)
                                FN_SLL:  dec_op = EXE_SLL_OP;
                                FN_SRL:  dec_op = EXE_SRL_OP;
                                default: dec_op = EXE_SRA_OP;
                            endcase
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign reg1_read_o = dec_r1;
    assign reg2_read_o = dec_r2;
    assign reg1_addr_o = RADDR_W'(rs);
    assign reg2_addr_o = RADDR_W'(rt);

    // r0 is hard zero; EX results beat MEM, and an EX load has no data yet
    function automatic logic [DATA_W-1:0] pick_operand(
        input logic en, input logic [RADDR_W-1:0] addr, input logic [DATA_W-1:0] rf_data,
        input logic [DATA_W-1:0] imm, input logic ex_fwd, input logic [RADDR_W-1:0] ex_wd,
        input logic [DATA_W-1:0] ex_wdata, input logic mem_wreg, input logic [RADDR_W-1:0] mem_wd,
        input logic [DATA_W-1:0] mem_wdata);
        if (!en)                                 return imm;
        else if (addr == '0)                     return '0;
        else if (ex_fwd && ex_wd == addr)        return ex_wdata;
        else if (mem_wreg && mem_wd == addr)     return mem_wdata;
        else                                     return rf_data;
    endfunction

    logic [DATA_W-1:0] op1, op2;
    logic ex_fwd, haz1, haz2, hazard, advance, load, bubble;

    assign ex_fwd = ex_wreg_i && !ex_load_i;
    assign op1 = pick_operand(dec_r1, reg1_addr_o, reg1_data_i, dec_imm, ex_fwd, ex_wd_i,
                              ex_wdata_i, mem_wreg_i, mem_wd_i, mem_wdata_i);
    assign op2 = pick_operand(dec_r2, reg2_addr_o, reg2_data_i, dec_imm, ex_fwd, ex_wd_i,
                              ex_wdata_i, mem_wreg_i, mem_wd_i, mem_wdata_i);

    assign haz1    = dec_r1 && reg1_addr_o != '0 && ex_wd_i == reg1_addr_o;
    assign haz2    = dec_r2 && reg2_addr_o != '0 && ex_wd_i == reg2_addr_o;
    assign hazard  = if_valid_i && ex_wreg_i && ex_load_i && (haz1 || haz2);
    assign advance = ex_ready_i || !ex_valid_o;
    assign load    = advance && if_valid_i && !hazard && !flush_i;
    assign bubble  = advance && hazard && !flush_i;
    assign id_ready_o = load;

    logic [0:0]          state_q, state_d;
    logic                valid_q, valid_d, wreg_q, wreg_d, inv_q, inv_d;
    logic [DATA_W-1:0]   pc_q, pc_d, reg1_q, reg1_d, reg2_q, reg2_d;
    logic [ALUOP_W-1:0]  aluop_q, aluop_d;
    logic [ALUSEL_W-1:0] alusel_q, alusel_d;
    logic [RADDR_W-1:0]  wd_q, wd_d;
    logic [CNT_W-1:0]    stall_q, stall_d;

    always_comb begin
        state_d = state_q; valid_d = valid_q; wreg_d = wreg_q; inv_d = inv_q;
        pc_d = pc_q; reg1_d = reg1_q; reg2_d = reg2_q;
        aluop_d = aluop_q; alusel_d = alusel_q; wd_d = wd_q;
        if (flush_i) begin
            valid_d = 1'b0; wreg_d = 1'b0; state_d = ST_RUN;
        end else if (advance) begin
            valid_d = load;
            state_d = hazard ? ST_BUBBLE : ST_RUN;
            if (load) begin
                pc_d = pc_i; reg1_d = op1; reg2_d = op2; aluop_d = dec_op;
                alusel_d = dec_sel; wd_d = dec_wd; wreg_d = dec_wreg; inv_d = dec_inv;
            end else begin
                wreg_d = 1'b0;
            end
        end
        stall_d = (bubble && stall_q != '1) ? stall_q + CNT_W'(1) : stall_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN; valid_q <= 1'b0; wreg_q <= 1'b0; inv_q <= 1'b0;
            pc_q <= '0; reg1_q <= '0; reg2_q <= '0; aluop_q <= EXE_NOP_OP;
            alusel_q <= EXE_RES_NOP; wd_q <= '0; stall_q <= '0;
        end else begin
            state_q <= state_d; valid_q <= valid_d; wreg_q <= wreg_d; inv_q <= inv_d;
            pc_q <= pc_d; reg1_q <= reg1_d; reg2_q <= reg2_d; aluop_q <= aluop_d;
            alusel_q <= alusel_d; wd_q <= wd_d; stall_q <= stall_d;
        end
    end

    assign ex_valid_o = valid_q;
    assign ex_pc_o = pc_q;
    assign aluOp_o = aluop_q;
    assign aluSel_o = alusel_q;
    assign reg1_o = reg1_q;
    assign reg2_o = reg2_q;
    assign wd_o = wd_q;
    assign wreg_o = wreg_q;
    assign inst_invalid_o = inv_q;
    assign stall_cnt_o = stall_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - directed and randomized check of id_stage_pipe against a behavioural model
module tb_id_stage_pipe;
    logic clk, rst, if_valid_i, id_ready_o, reg1_read_o, reg2_read_o;
    logic [31:0] pc_i, inst_i, reg1_data_i, reg2_data_i, ex_wdata_i, mem_wdata_i;
    logic [4:0] reg1_addr_o, reg2_addr_o, ex_wd_i, mem_wd_i, wd_o;
    logic ex_wreg_i, ex_load_i, mem_wreg_i, ex_ready_i, flush_i;
    logic ex_valid_o, wreg_o, inst_invalid_o;
    logic [31:0] ex_pc_o, reg1_o, reg2_o;
    logic [7:0] aluOp_o;
    logic [2:0] aluSel_o;
    logic [3:0] stall_cnt_o;

    id_stage_pipe #(.DATA_W(32), .RADDR_W(5), .ALUOP_W(8), .ALUSEL_W(3), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .pc_i(pc_i), .inst_i(inst_i),
        .id_ready_o(id_ready_o), .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
        .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .ex_wreg_i(ex_wreg_i), .ex_load_i(ex_load_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
        .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
        .ex_ready_i(ex_ready_i), .flush_i(flush_i), .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
        .aluOp_o(aluOp_o), .aluSel_o(aluSel_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
        .wd_o(wd_o), .wreg_o(wreg_o), .inst_invalid_o(inst_invalid_o), .stall_cnt_o(stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic ok; logic r1; logic r2; logic [31:0] imm; logic [7:0] op; logic [2:0] sel; logic [4:0] wd;
    } dec_t;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] rf [32];
    logic m_valid, m_wreg, m_inv;
    logic [31:0] m_pc, m_r1, m_r2;
    logic [7:0] m_op;
    logic [2:0] m_sel;
    logic [4:0] m_wd;
    logic [3:0] m_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Instruction semantics as a table: what each mnemonic reads, its immediate and its destination
    function automatic dec_t decode(input logic [31:0] i);
        dec_t d;
        logic [5:0] fn;
        logic [7:0] sop;
        fn = i[5:0];
        sop = (fn == 6'h00) ? 8'h7C : (fn == 6'h02) ? 8'h02 : 8'h03;
        d = '0;
        case (i[31:26])
            6'h0C: d = '{1'b1, 1'b1, 1'b0, 32'(i[15:0]), 8'h24, 3'd1, i[20:16]};
            6'h0D: d = '{1'b1, 1'b1, 1'b0, 32'(i[15:0]), 8'h25, 3'd1, i[20:16]};
            6'h0E: d = '{1'b1, 1'b1, 1'b0, 32'(i[15:0]), 8'h26, 3'd1, i[20:16]};
            6'h0F: d = '{1'b1, 1'b1, 1'b0, {i[15:0], 16'h0}, 8'h25, 3'd1, i[20:16]};
            6'h00: begin
                if (fn == 6'h24) d = '{1'b1, 1'b1, 1'b1, 32'h0, 8'h24, 3'd1, i[15:11]};
                if (fn == 6'h25) d = '{1'b1, 1'b1, 1'b1, 32'h0, 8'h25, 3'd1, i[15:11]};
                if (fn == 6'h26) d = '{1'b1, 1'b1, 1'b1, 32'h0, 8'h26, 3'd1, i[15:11]};
                if (fn == 6'h27) d = '{1'b1, 1'b1, 1'b1, 32'h0, 8'h27, 3'd1, i[15:11]};
                if ((fn inside {6'h00, 6'h02, 6'h03}) && i[25:21] == 5'd0)
                    d = '{1'b1, 1'b0, 1'b1, 32'(i[10:6]), sop, 3'd2, i[15:11]};
            end
            default: ;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] opnd(input logic [4:0] a, input logic [31:0] rfd);
        if (a == 5'd0) return 32'h0;
        if (ex_wreg_i && !ex_load_i && ex_wd_i == a) return ex_wdata_i;
        if (mem_wreg_i && mem_wd_i == a) return mem_wdata_i;
        return rfd;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_wreg = 0; m_inv = 0; m_pc = 0; m_r1 = 0; m_r2 = 0;
        m_op = 0; m_sel = 0; m_wd = 0; m_stall = 0;
    endtask

    task automatic check_regs();
        check("ex_valid", 32'(ex_valid_o), 32'(m_valid));
        check("wreg", 32'(wreg_o), 32'(m_wreg));
        check("ex_pc", ex_pc_o, m_pc);
        check("aluop", 32'(aluOp_o), 32'(m_op));
        check("alusel", 32'(aluSel_o), 32'(m_sel));
        check("reg1", reg1_o, m_r1);
        check("reg2", reg2_o, m_r2);
        check("wd", 32'(wd_o), 32'(m_wd));
        check("invalid", 32'(inst_invalid_o), 32'(m_inv));
        check("stall_cnt", 32'(stall_cnt_o), 32'(m_stall));
    endtask

    // Called just after a falling edge with inputs applied; returns at the next falling edge
    task automatic cycle();
        dec_t d;
        logic haz, adv;
        logic [31:0] o1, o2;
        #1;
        d = decode(inst_i);
        haz = if_valid_i && ex_wreg_i && ex_load_i &&
              ((d.r1 && inst_i[25:21] != 0 && ex_wd_i == inst_i[25:21]) ||
               (d.r2 && inst_i[20:16] != 0 && ex_wd_i == inst_i[20:16]));
        adv = ex_ready_i || !m_valid;
        check("id_ready", 32'(id_ready_o), 32'(if_valid_i && adv && !haz && !flush_i));
        check("reg1_read", 32'(reg1_read_o), 32'(d.r1));
        check("reg2_read", 32'(reg2_read_o), 32'(d.r2));
        if (d.r1) check("reg1_addr", 32'(reg1_addr_o), 32'(inst_i[25:21]));
        if (d.r2) check("reg2_addr", 32'(reg2_addr_o), 32'(inst_i[20:16]));
        o1 = d.r1 ? opnd(inst_i[25:21], reg1_data_i) : d.imm;
        o2 = d.r2 ? opnd(inst_i[20:16], reg2_data_i) : d.imm;
        if (flush_i) begin
            m_valid = 0; m_wreg = 0;
        end else if (adv) begin
            if (if_valid_i && !haz) begin
                m_valid = 1; m_pc = pc_i; m_op = d.op; m_sel = d.sel; m_r1 = o1; m_r2 = o2;
                m_wd = d.wd; m_wreg = d.ok; m_inv = !d.ok;
            end else begin
                m_valid = 0; m_wreg = 0;
            end
            if (haz && m_stall != 4'hF) m_stall = m_stall + 4'd1;
        end
        @(posedge clk);
        #1;
        check_regs();
        @(negedge clk);
    endtask

    task automatic quiet();
        ex_wreg_i = 0; ex_load_i = 0; ex_wd_i = 0; ex_wdata_i = 0;
        mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0; ex_ready_i = 1; flush_i = 0;
    endtask

    task automatic set_if(input logic [31:0] inst);
        if_valid_i = 1; inst_i = inst; pc_i = pc_i + 32'd4;
        reg1_data_i = rf[inst[25:21]]; reg2_data_i = rf[inst[20:16]];
    endtask

    task automatic load_hazard_setup();
        quiet(); ex_wreg_i = 1; ex_load_i = 1; ex_wd_i = 5'd4;
        set_if({6'h00, 5'd4, 5'd6, 5'd5, 5'd0, 6'h24});
    endtask

    function automatic logic [31:0] gen_inst();
        logic [4:0] rs, rt, rd, sh;
        logic [15:0] imm;
        logic [5:0] fn;
        rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3)); sh = 5'($urandom); imm = 16'($urandom);
        case ($urandom_range(0, 7))
            0: return {6'h0C, rs, rt, imm};
            1: return {6'h0D, rs, rt, imm};
            2: return {6'h0E, rs, rt, imm};
            3: return {6'h0F, 5'd0, rt, imm};
            4: begin fn = 6'h24 + 6'($urandom_range(0, 3)); return {6'h00, rs, rt, rd, 5'd0, fn}; end
            5: begin fn = 6'($urandom_range(0, 2)); if (fn == 6'd1) fn = 6'd3;
                     return {6'h00, 5'd0, rt, rd, sh, fn}; end
            6: return {6'h00, 5'($urandom_range(1, 3)), rt, rd, sh, 6'h00};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = 32'hDEADBEEF;
        rst = 0; if_valid_i = 0; pc_i = 0; inst_i = 0; reg1_data_i = 0; reg2_data_i = 0;
        quiet();
        model_reset();
        repeat (2) @(negedge clk);
        check_regs();
        rst = 1;

        // ORI r1,r0,0x1234 then OR r2,r1,r1 forwarded from EX (MEM holds stale r1)
        set_if({6'h0D, 5'd0, 5'd1, 16'h1234});
        cycle();
        check("ori_reg2", reg2_o, 32'h00001234);
        check("ori_wd", 32'(wd_o), 32'd1);
        set_if({6'h00, 5'd1, 5'd1, 5'd2, 5'd0, 6'h25});
        ex_wreg_i = 1; ex_wd_i = 5'd1; ex_wdata_i = 32'h00001234;
        mem_wreg_i = 1; mem_wd_i = 5'd1; mem_wdata_i = 32'h0BAD0BAD;
        cycle();
        check("fwd_reg1", reg1_o, 32'h00001234);
        check("fwd_reg2", reg2_o, 32'h00001234);
        check("fwd_wd", 32'(wd_o), 32'd2);
        check("fwd_wreg", 32'(wreg_o), 32'd1);

        // r0 is never forwarded
        quiet(); ex_wreg_i = 1; ex_wd_i = 5'd0; ex_wdata_i = 32'hFFFFFFFF;
        mem_wreg_i = 1; mem_wd_i = 5'd0; mem_wdata_i = 32'hFFFFFFFF;
        set_if({6'h0D, 5'd0, 5'd3, 16'h0005});
        cycle();
        check("r0_reg1", reg1_o, 32'h0);
        check("r0_reg2", reg2_o, 32'h5);

        // load-use: one bubble, then MEM supplies the load data
        load_hazard_setup();
        #1 check("lu_ready", 32'(id_ready_o), 32'd0);
        cycle();
        check("lu_bubble", 32'(ex_valid_o), 32'd0);
        check("lu_stall", 32'(stall_cnt_o), 32'd1);
        quiet(); mem_wreg_i = 1; mem_wd_i = 5'd4; mem_wdata_i = 32'hA5A5A5A5;
        #1 check("lu_release", 32'(id_ready_o), 32'd1);
        cycle();
        check("lu_reg1", reg1_o, 32'hA5A5A5A5);
        check("lu_valid", 32'(ex_valid_o), 32'd1);

        // EX backpressure for three cycles, then release
        quiet(); ex_ready_i = 0;
        set_if({6'h0E, 5'd1, 5'd7, 16'h00FF});
        repeat (3) begin
            #1 check("bp_ready", 32'(id_ready_o), 32'd0);
            cycle();
            check("bp_reg1", reg1_o, 32'hA5A5A5A5);
            check("bp_wd", 32'(wd_o), 32'd5);
            check("bp_valid", 32'(ex_valid_o), 32'd1);
        end
        ex_ready_i = 1;
        cycle();
        check("rel_wd", 32'(wd_o), 32'd7);
        check("rel_reg2", reg2_o, 32'h000000FF);

        // flush with a hazard pending
        load_hazard_setup(); flush_i = 1;
        cycle();
        check("fl_valid", 32'(ex_valid_o), 32'd0);
        check("fl_wreg", 32'(wreg_o), 32'd0);
        check("fl_stall", 32'(stall_cnt_o), 32'd1);
        quiet(); set_if({6'h0D, 5'd0, 5'd1, 16'h0001});
        cycle();
        check("fl_run", 32'(ex_valid_o), 32'd1);

        // unrecognised opcode
        quiet(); set_if({6'h3F, 26'h1555555});
        cycle();
        check("inv_flag", 32'(inst_invalid_o), 32'd1);
        check("inv_wreg", 32'(wreg_o), 32'd0);

        // saturating stall counter
        load_hazard_setup();
        repeat (16) cycle();
        check("stall_sat", 32'(stall_cnt_o), 32'hF);
        cycle();
        check("stall_hold", 32'(stall_cnt_o), 32'hF);

        for (int n = 0; n < 400; n++) begin
            ex_wreg_i = 1'($urandom); ex_load_i = ($urandom_range(0, 2) == 0);
            ex_wd_i = 5'($urandom_range(0, 3)); ex_wdata_i = $urandom;
            mem_wreg_i = 1'($urandom); mem_wd_i = 5'($urandom_range(0, 3)); mem_wdata_i = $urandom;
            ex_ready_i = ($urandom_range(0, 9) < 7); flush_i = ($urandom_range(0, 9) == 0);
            set_if(gen_inst());
            if_valid_i = ($urandom_range(0, 9) < 8); pc_i = $urandom;
            cycle();
        end

        // asynchronous reset in the middle of a stall
        load_hazard_setup();
        cycle();
        #2 rst = 0;
        #1 model_reset();
        check_regs();
        @(negedge clk);
        rst = 1;
        quiet(); mem_wreg_i = 1; mem_wd_i = 5'd4; mem_wdata_i = 32'h5A5A5A5A;
        cycle();
        check("rst_reload_valid", 32'(ex_valid_o), 32'd1);
        check("rst_reload_reg1", reg1_o, 32'h5A5A5A5A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
